// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder.
// Access sizes and responder FSM states.
package dmem_pkg;

   localparam logic [1:0] BHW_BYTE = 2'd0;
   localparam logic [1:0] BHW_HALF = 2'd1;
   localparam logic [1:0] BHW_WORD = 2'd2;
   localparam logic [1:0] BHW_RSVD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage and the responder.
// The master issues requests and consumes responses.
interface dmem_responder_if;

   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [63:0] ReqAddr;
   logic [63:0] ReqWData;
   logic [1:0]  ReqBHW;
   logic        ReqSignExt;
   logic        RespValid;
   logic        RespReady;
   logic [63:0] RespRData;
   logic        RespError;

   modport master (
      output ReqValid, ReqWrite, ReqAddr, ReqWData,
      output ReqBHW, ReqSignExt, RespReady,
      input  ReqReady, RespValid, RespRData, RespError
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqAddr, ReqWData,
      input  ReqBHW, ReqSignExt, RespReady,
      output ReqReady, RespValid, RespRData, RespError
   );

endinterface

// File: rtl/dmem_lane_extract.sv
// Selects the addressed byte/half/word from a memory word
// and zero- or sign-extends it to 64 bits.
module dmem_lane_extract
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [1:0]  bhw,
   input  logic        signext,
   output logic [63:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{addr, 3'b000} +: 8];
   assign half_sel = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      data = '0;
      unique case (1'b1)
         bhw == BHW_BYTE:
            data = {{56{signext & byte_sel[7]}}, byte_sel};
         bhw == BHW_HALF:
            data = {{48{signext & half_sel[15]}}, half_sel};
         bhw == BHW_WORD:
            data = {{32{signext & word[31]}}, word};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable
// wait states, alignment/range checking and sub-word stores.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 32,
   parameter int WAIT_CYCLES = 2
)
(
   input  logic Clk,
   input  logic Reset,
   dmem_responder_if.slave bus
);

   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam int IW = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept, access, done;

   logic          wr_q, sext_q;
   logic [63:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [1:0]    bhw_q;

   logic [63:0]   rdata_q;
   logic          error_q;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [IW-1:0] idx;
   logic [31:0]   word, lane_data, merged;
   logic [3:0]    be;
   logic          err;
   logic [63:0]   load_data;
   logic          unused_wdata;

   assign unused_wdata = ^bus.ReqWData[63:32];

   assign bus.ReqReady  = (state_q == ST_IDLE);
   assign bus.RespValid = (state_q == ST_RESP);
   assign bus.RespRData = rdata_q;
   assign bus.RespError = error_q;

   assign idx  = addr_q[IW+1:2];
   assign word = mem[idx];

   // Range check uses the full address so high bits never alias.
   assign err = (bhw_q == BHW_RSVD)
              | ((bhw_q == BHW_HALF) & addr_q[0])
              | ((bhw_q == BHW_WORD) & (|addr_q[1:0]))
              | ((addr_q >> 2) >= 64'(DEPTH_WORDS));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.ReqValid) begin
               accept  = 1'b1;
               cnt_d   = CW'(WAIT_CYCLES);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               access  = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.RespReady) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      be        = '0;
      lane_data = '0;
      unique case (1'b1)
         bhw_q == BHW_BYTE: begin
            be        = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
         end
         bhw_q == BHW_HALF: begin
            be        = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
         end
         bhw_q == BHW_WORD: begin
            be        = 4'b1111;
            lane_data = wdata_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      merged = word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
      end
   end

   dmem_lane_extract u_extract (
      .word    (word),
      .addr    (addr_q[1:0]),
      .bhw     (bhw_q),
      .signext (sext_q),
      .data    (load_data)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_q    <= 1'b0;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         bhw_q   <= BHW_BYTE;
      end else if (accept) begin
         wr_q    <= bus.ReqWrite;
         sext_q  <= bus.ReqSignExt;
         addr_q  <= bus.ReqAddr;
         wdata_q <= bus.ReqWData[31:0];
         bhw_q   <= bus.ReqBHW;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rdata_q <= '0;
         error_q <= 1'b0;
      end else if (access) begin
         error_q <= err;
         rdata_q <= (err | wr_q) ? '0 : load_data;
      end else if (done) begin
         rdata_q <= '0;
         error_q <= 1'b0;
      end
   end

   // Array contents survive reset; a reset edge still blocks the commit.
   always_ff @(posedge Clk) begin
      if (!Reset && access && wr_q && !err) begin
         mem[idx] <= merged;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against
// a byte-array style reference model.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int DEPTH = 32;
   localparam int WAITC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] rmem [DEPTH];

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: size in bytes, natural alignment, word-index range.
   task automatic model(input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [1:0] bhw,
                        input logic sx, output logic err,
                        output logic [63:0] data);
      int n, off, wi;
      logic [63:0] w, mask;
      n    = 1 << bhw;
      off  = int'(addr % 4);
      err  = (bhw == 2'd3) || (addr % n != 0) || ((addr / 4) >= DEPTH);
      data = '0;
      if (err) return;
      wi   = int'(addr / 4);
      mask = (64'd1 << (8 * n)) - 64'd1;
      if (wr) begin
         w = 64'(rmem[wi]);
         w = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
         rmem[wi] = w[31:0];
      end else begin
         w = (64'(rmem[wi]) >> (8 * off)) & mask;
         if (sx && w[8 * n - 1]) w = w | ~mask;
         data = w;
      end
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (bus.RespValid !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic drive(input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [1:0] bhw,
                        input logic sx);
      bus.ReqValid   = 1'b1;
      bus.ReqWrite   = wr;
      bus.ReqAddr    = addr;
      bus.ReqWData   = wd;
      bus.ReqBHW     = bhw;
      bus.ReqSignExt = sx;
   endtask

   task automatic txn(input logic wr, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [1:0] bhw,
                      input logic sx, input string tag,
                      output logic [63:0] got);
      logic        eerr;
      logic [63:0] edata;
      int          n;
      @(negedge clk);
      chk({tag, "/req_ready"}, 64'(bus.ReqReady), 64'd1);
      drive(wr, addr, wd, bhw, sx);
      @(posedge clk);
      #1;
      bus.ReqValid = 1'b0;
      wait_resp(n);
      chk({tag, "/latency"}, 64'(n), 64'(WAITC + 1));
      model(wr, addr, wd, bhw, sx, eerr, edata);
      got = bus.RespRData;
      chk({tag, "/rdata"}, bus.RespRData, edata);
      chk({tag, "/error"}, 64'(bus.RespError), 64'(eerr));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      bus.RespReady = 1'b1;
      @(posedge clk);
      #1;
      bus.RespReady = 1'b0;
      chk({tag, "/after_hs"},
          {61'd0, bus.RespValid, bus.ReqReady, bus.RespError},
          64'b010);
      chk({tag, "/after_hs_data"}, bus.RespRData, 64'd0);
   endtask

   initial begin
      logic [63:0] g, a, d0, d1;
      logic        e0, e1;
      int          n;

      bus.ReqValid   = 1'b0;
      bus.ReqWrite   = 1'b0;
      bus.ReqAddr    = '0;
      bus.ReqWData   = '0;
      bus.ReqBHW     = BHW_BYTE;
      bus.ReqSignExt = 1'b0;
      bus.RespReady  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst/req_ready", 64'(bus.ReqReady), 64'd1);
      chk("rst/resp_valid", 64'(bus.RespValid), 64'd0);
      chk("rst/rdata", bus.RespRData, 64'd0);
      chk("rst/error", 64'(bus.RespError), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         txn(1'b1, 64'(4 * i), {$urandom, $urandom}, BHW_WORD,
             1'b0, "init", g);
      end

      txn(1'b1, 64'h8, 64'hDEADBEEF, BHW_WORD, 1'b0, "st8", g);
      chk("st8/zero", g, 64'd0);
      txn(1'b0, 64'h8, 64'd0, BHW_WORD, 1'b0, "ld8", g);
      chk("ld8/value", g, 64'h00000000DEADBEEF);

      txn(1'b1, 64'h4, 64'd0, BHW_WORD, 1'b0, "st4", g);
      txn(1'b1, 64'h5, 64'h80, BHW_BYTE, 1'b0, "stb5", g);
      txn(1'b0, 64'h5, 64'd0, BHW_BYTE, 1'b1, "ldb5s", g);
      chk("ldb5s/value", g, 64'hFFFFFFFFFFFFFF80);
      txn(1'b0, 64'h5, 64'd0, BHW_BYTE, 1'b0, "ldb5z", g);
      chk("ldb5z/value", g, 64'h80);
      txn(1'b0, 64'h4, 64'd0, BHW_WORD, 1'b0, "ld4a", g);
      chk("ld4a/value", g, 64'h00008000);

      txn(1'b1, 64'h6, 64'h8001, BHW_HALF, 1'b0, "sth6", g);
      txn(1'b0, 64'h6, 64'd0, BHW_HALF, 1'b1, "ldh6", g);
      chk("ldh6/value", g, 64'hFFFFFFFFFFFF8001);
      txn(1'b0, 64'h4, 64'd0, BHW_WORD, 1'b0, "ld4b", g);
      chk("ld4b/value", g, 64'h80018000);

      txn(1'b1, 64'h3, 64'hFFFF, BHW_HALF, 1'b0, "err_half3", g);
      txn(1'b0, 64'h0, 64'd0, BHW_WORD, 1'b0, "ld0_unchanged", g);
      txn(1'b0, 64'h80, 64'd0, BHW_WORD, 1'b0, "err_oob", g);
      txn(1'b1, 64'h1_0000_0008, 64'h5A5A5A5A, BHW_WORD, 1'b0,
          "err_nowrap", g);
      txn(1'b1, 64'h0, 64'h1234, 2'd3, 1'b0, "err_rsvd", g);
      txn(1'b0, 64'h8, 64'd0, BHW_WORD, 1'b0, "ld8_unchanged", g);

      // Backpressure with a competing request held on the bus.
      @(negedge clk);
      drive(1'b0, 64'h4, 64'd0, BHW_WORD, 1'b0);
      @(posedge clk);
      #1;
      bus.ReqValid = 1'b0;
      wait_resp(n);
      chk("bp/latency", 64'(n), 64'(WAITC + 1));
      model(1'b0, 64'h4, 64'd0, BHW_WORD, 1'b0, e0, d0);
      @(negedge clk);
      drive(1'b0, 64'h5, 64'd0, BHW_BYTE, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp/hold_valid", 64'(bus.RespValid), 64'd1);
         chk("bp/hold_data", bus.RespRData, d0);
         chk("bp/hold_error", 64'(bus.RespError), 64'(e0));
         chk("bp/hold_ready", 64'(bus.ReqReady), 64'd0);
      end
      @(negedge clk);
      bus.RespReady = 1'b1;
      @(posedge clk);
      #1;
      bus.RespReady = 1'b0;
      chk("bp/hs_idle", {62'd0, bus.RespValid, bus.ReqReady}, 64'b01);
      @(posedge clk);
      #1;
      bus.ReqValid = 1'b0;
      chk("bp/accept_next", 64'(bus.ReqReady), 64'd0);
      wait_resp(n);
      chk("bp2/latency", 64'(n), 64'(WAITC + 1));
      model(1'b0, 64'h5, 64'd0, BHW_BYTE, 1'b1, e1, d1);
      chk("bp2/rdata", bus.RespRData, d1);
      chk("bp2/error", 64'(bus.RespError), 64'(e1));
      @(negedge clk);
      bus.RespReady = 1'b1;
      @(posedge clk);
      #1;
      bus.RespReady = 1'b0;

      // Reset while the store is waiting.
      @(negedge clk);
      drive(1'b1, 64'h8, 64'h12345678, BHW_WORD, 1'b0);
      @(posedge clk);
      #1;
      bus.ReqValid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_busy/req_ready", 64'(bus.ReqReady), 64'd1);
      chk("rst_busy/resp_valid", 64'(bus.RespValid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      txn(1'b0, 64'h8, 64'd0, BHW_WORD, 1'b0, "rst_busy_ld", g);
      chk("rst_busy_ld/value", g, 64'h00000000DEADBEEF);

      // Reset landing exactly on the access edge.
      @(negedge clk);
      drive(1'b1, 64'h8, 64'h12345678, BHW_WORD, 1'b0);
      @(posedge clk);
      #1;
      bus.ReqValid = 1'b0;
      repeat (WAITC) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_acc/resp_valid", 64'(bus.RespValid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      txn(1'b0, 64'h8, 64'd0, BHW_WORD, 1'b0, "rst_acc_ld", g);
      chk("rst_acc_ld/value", g, 64'h00000000DEADBEEF);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
         else a = 64'($urandom_range(0, 4 * DEPTH + 7));
         txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             "rand", g);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target end of the load/store path driven by the CPU datapath's memory stage.
- Accepts one request at a time (byte/half/word, read or write) and waits a programmable number of cycles.
- Performs the access on an internal word array.
- Returns read data (zero- or sign-extended to 64 bits) or an error flag over a valid/ready response channel.

Parameters:
- DEPTH_WORDS, 32, number of 32-bit words in the internal array; legal word index 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, extra wait states before the access; 0 is legal.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  responder can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  64  byte address.
- ReqWData  in  64  store data; low bytes used per ReqBHW.
- ReqBHW  in  2  size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- ReqSignExt  in  1  1 = sign-extend load data; 0 = zero-extend.
- RespValid  out  1  response present.
- RespReady  in  1  consumer takes the response.
- RespRData  out  64  load data; 0 for stores and errors.
- RespError  out  1  access rejected.

Behaviour:
- Reset and clocking:
  - One clock (Clk). Reset is synchronous and active-high; Reset wins over every other event on the same edge.
  - After the reset edge: state IDLE, ReqReady=1, RespValid=0, RespRData=0, RespError=0, wait counter=0.
  - The memory array is not cleared by reset.
- States: IDLE, BUSY, RESP. ReqReady = (state==IDLE). RespValid = (state==RESP).
- IDLE:
  - A request is accepted on an edge with ReqValid & ReqReady.
  - On that edge: latch ReqWrite, ReqAddr, ReqWData, ReqBHW and ReqSignExt; load counter with WAIT_CYCLES; go to BUSY.
- BUSY:
  - If counter != 0: decrement the counter.
  - If counter == 0: perform the access on this edge, register RespRData/RespError, go to RESP.
  - BUSY lasts WAIT_CYCLES+1 cycles, so RespValid rises WAIT_CYCLES+1 edges after the accept edge.
- RESP:
  - RespValid, RespRData and RespError stay stable until RespReady=1.
  - On the handshake edge go to IDLE and clear RespRData/RespError to 0.
  - A new request cannot be accepted on the same edge; it is accepted at the earliest on the next edge.
- One outstanding request only. ReqValid is ignored outside IDLE.
- Error checks, evaluated on the access edge:
  - ReqBHW==3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index (addr>>2) >= DEPTH_WORDS, using the full 64-bit address (no wrap).
  - On error: RespError=1, RespRData=0, no array write.
- Store:
  - Byte writes WData[7:0] into lane addr[1:0].
  - Half writes WData[15:0] into the lane pair selected by addr[1].
  - Word writes WData[31:0].
  - Other lanes are preserved. RespRData=0.
- Load:
  - Byte selects bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half selects the lane pair by addr[1].
  - Word selects the full 32 bits.
  - Extension to 64 bits: sign-extend if ReqSignExt and the selected MSB is 1, else zero-extend.
- Reset mid-operation: the pending request is dropped. A write not yet committed is never committed. A pending response is discarded.
- Read-after-write: a load accepted after a store's response sees the stored data.

Decomposition:
- Shared package dmem_pkg: BHW_BYTE=0, BHW_HALF=1, BHW_WORD=2, BHW_RSVD=3; state encodings ST_IDLE, ST_BUSY, ST_RESP.
- Sub-module dmem_lane_extract, combinational: (word[31:0], addr[1:0], bhw, signext) -> data[63:0].
- Top module holds the FSM, counter, array, error checks and store-merge logic.

Test Plan:
- Write-then-read (WAIT_CYCLES=2):
  - Word store 0xDEADBEEF at 0x8 -> RespValid 3 edges after accept, RespRData=0, RespError=0.
  - Word load 0x8, signext=0 -> 0x00000000DEADBEEF.
- Byte lane and sign extension:
  - After word 0 at 0x4, byte store 0x80 at 0x5.
  - Byte load at 0x5: signext=1 -> 0xFFFFFFFFFFFFFF80; signext=0 -> 0x80.
  - Word load at 0x4 -> 0x00008000.
- Half access: half store 0x8001 at 0x6; half load 0x6 signext=1 -> 0xFFFFFFFFFFFF8001; word load at 0x4 -> 0x80018000.
- Errors:
  - Half at 0x3 -> RespError=1, data 0, memory unchanged.
  - Word at 0x80 (DEPTH_WORDS=32) -> RespError=1.
  - BHW=3 -> RespError=1.
- Backpressure: hold RespReady=0 for 5 cycles -> RespValid/RespRData/RespError stable, ReqReady=0, a concurrent ReqValid is not accepted; accept happens only after the handshake.
- Reset mid-operation:
  - Assert Reset during BUSY of word store 0x12345678 at 0x8 -> next cycle IDLE, ReqReady=1, RespValid=0.
  - Subsequent load at 0x8 returns the old 0xDEADBEEF.
